int2float_share_ctrl: RTL and testbench

- Sequencer and round-robin arbiter that shares one combinational int2float converter among NUM_REQ requesters.
- Converter: 11-bit integer B in; 4-bit mantissa M and 3-bit exponent E out.
- Per requester: accepts an 11-bit operand over a valid/ready handshake, drives the registered operand into the shared converter, waits a programmable settle time, returns M/E to the same requester over a second valid/ready handshake.
- Sits between the requester ports and the single int2float instance in the numeric front end.

---
 rtl/int2float_share_ctrl.sv | 154 +++++++++++++++
 tb/tb_int2float_share_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_share_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : int2float_share_ctrl
// Purpose  : Round-robin sequencer sharing one combinational int2float
//            converter (11-bit B in, 4-bit M / 3-bit E out) among NUM_REQ
//            requesters over valid/ready request and response handshakes.
// Option   : INT2FLOAT_SHARE_PRIO0_EN - requester 0 gets absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module int2float_share_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int CONV_CYC = 1,
  parameter int IDX_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*11-1:0]  req_data,
  output logic [10:0]            conv_b,
  input  logic [3:0]             conv_m,
  input  logic [2:0]             conv_e,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [3:0]             rsp_m,
  output logic [2:0]             rsp_e,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [IDX_W-1:0]     gnt_q;
  logic [10:0]          op_q;
  logic [3:0]           cnt_q;
  logic [3:0]           rsp_m_q;
  logic [2:0]           rsp_e_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;

  logic                 w_win_any;
  logic [IDX_W-1:0]     w_win_idx;
  logic [10:0]          w_win_data;
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic                 w_rsp_done;
  int                   w_dist;
  int                   w_best;

  // Arbitration: nearest valid requester at or after rr_ptr (modulo NUM_REQ)
  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    w_dist     = 0;
    w_best     = NUM_REQ;
    w_win_any  = |req_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_win_idx  = IDX_W'(i);
        w_win_data = req_data[i*11 +: 11];
      end
    end
`ifdef INT2FLOAT_SHARE_PRIO0_EN
    // Requester 0 overrides the rotation whenever it is asking
    if (req_valid[0]) begin
      w_win_idx  = '0;
      w_win_data = req_data[10:0];
    end
`endif
  end

  // Decode of the current owner, accept strobes and response completion
  always_comb begin
    w_gnt_oh  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i]  = (gnt_q == IDX_W'(i));
      req_ready[i] = !rst && (state_q == S_IDLE) && w_win_any &&
                     (w_win_idx == IDX_W'(i));
    end
    w_rsp_done = |(rsp_ready & w_gnt_oh);
  end

  // Pointer moves to the requester after the one just served
  always_comb begin
    rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
`ifdef INT2FLOAT_SHARE_PRIO0_EN
    // Requester 0 traffic must not disturb the rotation of the others
    if (gnt_q == '0) begin
      rr_ptr_d = rr_ptr_q;
    end
`endif
  end

  // Sequencer: accept operand, hold it on the converter, return result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_m_q     <= '0;
      rsp_e_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_win_any) begin
            op_q    <= w_win_data;
            gnt_q   <= w_win_idx;
            cnt_q   <= 4'(CONV_CYC - 1);
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_m_q     <= conv_m;
            rsp_e_q     <= conv_e;
            rsp_valid_q <= w_gnt_oh;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_done) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conv_b    = op_q;
  assign rsp_m     = rsp_m_q;
  assign rsp_e     = rsp_e_q;
  assign rsp_valid = rsp_valid_q;
  assign gnt_idx   = gnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_int2float_share_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_int2float_share_ctrl
// Purpose  : Scoreboard bench for int2float_share_ctrl with a behavioural
//            int2float converter on the shared port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int2float_share_ctrl;

  localparam int NREQ = 4;
  localparam int CCYC = 3;
  localparam int IW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*11-1:0] req_data;
  logic [10:0]       conv_b;
  logic [3:0]        conv_m;
  logic [2:0]        conv_e;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [3:0]        rsp_m;
  logic [2:0]        rsp_e;
  logic [IW-1:0]     gnt_idx;
  logic              busy;

  always #5 clk = ~clk;

  int2float_share_ctrl #(.NUM_REQ(NREQ), .CONV_CYC(CCYC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .conv_b(conv_b), .conv_m(conv_m), .conv_e(conv_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_m(rsp_m), .rsp_e(rsp_e), .gnt_idx(gnt_idx), .busy(busy)
  );

  // Shared converter: M = 4 bits below and including the leading one, E = shift
  function automatic logic [6:0] i2f(input logic [10:0] b);
    int p;
    p = -1;
    for (int i = 0; i < 11; i++) if (b[i]) p = i;
    if (p < 4) return {b[3:0], 3'd0};
    return {4'(b >> (p - 3)), 3'(p - 3)};
  endfunction
  assign {conv_m, conv_e} = i2f(conv_b);

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] m;
    logic [2:0] e;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   rsp_cnt = 0;
  int   exp_total = 0;

  // Hand-computed converter results for the burst operands
  logic [10:0] exp_b [4] = '{11'h001, 11'h010, 11'h100, 11'h7FF};
  logic [3:0]  exp_m [4] = '{4'h1, 4'h8, 4'h8, 4'hF};
  logic [2:0]  exp_e [4] = '{3'd0, 3'd1, 3'd5, 3'd7};

  logic [3:0] b_mask  [8];
  int         b_order [8];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void push_exp(input int r, input logic [3:0] m, input logic [2:0] e);
    exp_t x;
    x.idx = 3'(r);
    x.m   = m;
    x.e   = e;
    sb.push_back(x);
    exp_total++;
  endfunction

  // Monitor: checks one-hot response and scores each completed handshake
  always @(negedge clk) begin
    exp_t x;
    if (!rst && (rsp_valid != '0)) begin
      chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
      if ((rsp_valid & rsp_ready) != '0) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp_idx", 32'(oh2i(rsp_valid)), 32'hFFFF_FFFF);
        end else begin
          x = sb.pop_front();
          chk("rsp_idx", 32'(oh2i(rsp_valid)), 32'(x.idx));
          chk("rsp_m", 32'(rsp_m), 32'(x.m));
          chk("rsp_e", 32'(rsp_e), 32'(x.e));
        end
      end
    end
  end

  // Returns at the negedge before the accept edge; w = granted index or -1
  task automatic wait_accept(output int w);
    w = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != '0) begin
        w = oh2i(req_ready);
        break;
      end
    end
    if (w < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue n grants; before each, requesters follow b_mask, grant must follow b_order
  task automatic run_burst(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      req_valid = b_mask[k];
      push_exp(b_order[k], exp_m[b_order[k]], exp_e[b_order[k]]);
      wait_accept(w);
      chk("grant_order", 32'(w), 32'(b_order[k]));
      @(posedge clk);
      #1;
      chk("gnt_idx", 32'(gnt_idx), 32'(b_order[k]));
      chk("conv_b", 32'(conv_b), 32'(exp_b[b_order[k]]));
    end
    req_valid = '0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int edges;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    rsp_ready = '0;

    // Reset values, with requests pending to prove req_ready is held low
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_state", {26'd0, rsp_valid, busy, gnt_idx != '0}, 32'd0);
    chk("rst_conv_b", 32'(conv_b), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;

    // Reset in the middle of a requester-2 conversion
    req_data[2*11 +: 11] = 11'h155;
    req_valid = 4'b0100;
    wait_accept(w);
    chk("midrst_grant", 32'(w), 32'd2);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_conv_b", 32'(conv_b), 32'h155);
    rst = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_outs", {20'd0, rsp_valid, busy, gnt_idx, 4'd0}, 32'd0);
    chk("midrst_conv_b0", 32'(conv_b), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (12) @(posedge clk);
    #1 chk("midrst_idle", 32'(busy), 32'd0);

    // Single operation with latency measurement
    rsp_ready = 4'b0010;
    req_data[1*11 +: 11] = 11'h3FF;
    push_exp(1, 4'hF, 3'd6);
    req_valid = 4'b0010;
    wait_accept(w);
    chk("single_grant", 32'(w), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    edges = 1;
    chk("single_conv_b", 32'(conv_b), 32'h3FF);
    chk("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    while (!rsp_valid[1] && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("single_latency", 32'(edges), 32'd4);
    wait_drain();

    // Round-robin from reset, all requesters continuously valid
    pulse_reset();
    req_data  = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    rsp_ready = 4'hF;
    b_mask  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    b_order = '{0, 1, 2, 3, 0, 0, 0, 0};
    run_burst(5);

    // Backpressure on requester 3, wrong-index rsp_ready ignored
    rsp_ready = '0;
    push_exp(3, 4'hF, 3'd7);
    req_valid = 4'b1000;
    wait_accept(w);
    chk("bp_grant", 32'(w), 32'd3);
    @(posedge clk);
    #1 req_valid = '0;
    for (int t = 0; t < 20 && !rsp_valid[3]; t++) @(posedge clk);
    #1;
    rsp_ready = 4'b0001;
    req_valid = 4'b0001;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_m, rsp_e, req_ready, busy},
          {4'b1000, 4'hF, 3'd7, 4'b0000, 1'b1});
    end
    req_valid = '0;
    rsp_ready = 4'b1000;
    wait_drain();

    // Requester 2 withdraws while the block is busy
    rsp_ready = 4'hF;
    push_exp(1, exp_m[1], exp_e[1]);
    req_valid = 4'b0010;
    wait_accept(w);
    chk("wd_grant", 32'(w), 32'd1);
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(negedge clk);
    chk("wd_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();
    repeat (10) @(posedge clk);
    #1 chk("wd_idle", 32'(busy), 32'd0);

`ifdef INT2FLOAT_SHARE_PRIO0_EN
    // Requester 0 keeps winning; requester 2 served once 0 drops
    b_mask  = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0};
    b_order = '{0, 0, 0, 2, 0, 0, 0, 0};
    run_burst(4);
`else
    // Pointer sits at 2 after the last completion: 2, 0, 2
    b_mask  = '{4'b0101, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    b_order = '{2, 0, 2, 0, 0, 0, 0, 0};
    run_burst(3);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("rsp_count", 32'(rsp_cnt), 32'(exp_total));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
